// File: rtl/vmicro16_apb_gpio_halt_pkg.sv
// Shared definitions for the APB GPIO / halt collector peripheral.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
// Contents: SoC-level widths, register word offsets and the APB slave state encoding.
package vmicro16_apb_gpio_halt_pkg;

  localparam int APB_DATA_W     = 16;
  localparam int APB_GPIO1_PINS = 16;
  localparam int SOC_CORES      = 4;

  // Register word offsets
  localparam int APB_GPIOH_DATA  = 0;
  localparam int APB_GPIOH_SET   = 1;
  localparam int APB_GPIOH_CLR   = 2;
  localparam int APB_GPIOH_TOG   = 3;
  localparam int APB_GPIOH_HMASK = 4;
  localparam int APB_GPIOH_HSTAT = 5;
  localparam int APB_GPIOH_HCNT  = 6;

  typedef enum logic [1:0] {
    APB_IDLE = 2'd0,
    APB_WAIT = 2'd1,
    APB_DONE = 2'd2
  } apb_state_t;

endpackage

// File: rtl/vmicro16_apb_slave_fsm.sv
// APB3 slave handshake: one wait state, then a single registered PREADY pulse.
// Latency: PREADY high in the 2nd access cycle; wr_en/rd_en strobe in the 1st access cycle.
// Backpressure: always inserts exactly one wait state; no re-pulse until PSELx falls.
// Ports: clk/reset (sync, active-high), psel/penable/pwrite from the master,
//        pready to the master, wr_en/rd_en strobes to the register file.
module vmicro16_apb_slave_fsm
  import vmicro16_apb_gpio_halt_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic psel,
  input  logic penable,
  input  logic pwrite,
  output logic pready,
  output logic wr_en,
  output logic rd_en
);

  apb_state_t state_q, state_d;
  logic       pready_q, pready_d;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= APB_IDLE;
      pready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pready_q <= pready_d;
    end
  end

  // Next state: a setup phase must be observed before an access is accepted,
  // so a master caught mid-transfer by reset has to restart from setup.
  always_comb begin
    state_d = state_q;
    case (state_q)
      APB_IDLE: if (psel && !penable) state_d = APB_WAIT;
      APB_WAIT: begin
        if (!psel)        state_d = APB_IDLE;
        else if (penable) state_d = APB_DONE;
      end
      APB_DONE: if (!psel) state_d = APB_IDLE;
      default:  state_d = APB_IDLE;
    endcase
  end

  // Outputs: the first access cycle is the wait state; its strobe commits
  // on the same edge that raises PREADY.
  always_comb begin
    logic xfer;
    xfer     = (state_q == APB_WAIT) && psel && penable;
    wr_en    = xfer && pwrite;
    rd_en    = xfer && !pwrite;
    pready_d = xfer;
  end

  assign pready = pready_q;

endmodule

// File: rtl/vmicro16_apb_gpio_halt.sv
// APB3 slave owning the SoC result GPIO register and the top-level halt collector.
// Latency: writes/read data land on the PREADY edge (1 wait state); halt is 1 clk after the last enabled core halts.
// Backpressure: fixed one-wait-state APB response, never stalls longer.
// Ports: clk/reset (sync, active-high); S_P* APB3 slave; core_halt per-core levels;
//        gpio result port; halt = all enabled cores halted (registered).
module vmicro16_apb_gpio_halt
  import vmicro16_apb_gpio_halt_pkg::*;
#(
  parameter int PINS   = APB_GPIO1_PINS,
  parameter int CORES  = SOC_CORES,
  parameter int ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     S_PADDR,
  input  logic                  S_PSELx,
  input  logic                  S_PENABLE,
  input  logic                  S_PWRITE,
  input  logic [APB_DATA_W-1:0] S_PWDATA,
  output logic [APB_DATA_W-1:0] S_PRDATA,
  output logic                  S_PREADY,
  input  logic [CORES-1:0]      core_halt,
  output logic [PINS-1:0]       gpio,
  output logic                  halt
);

  logic wr_en, rd_en;

  vmicro16_apb_slave_fsm u_fsm (
    .clk     (clk),
    .reset   (reset),
    .psel    (S_PSELx),
    .penable (S_PENABLE),
    .pwrite  (S_PWRITE),
    .pready  (S_PREADY),
    .wr_en   (wr_en),
    .rd_en   (rd_en)
  );

  logic [PINS-1:0]       gpio_q, gpio_d;
  logic [CORES-1:0]      hmask_q, hmask_d;
  logic [CORES-1:0]      hstat_q, hstat_d;
  logic [15:0]           hcnt_q, hcnt_d;
  logic                  halt_q, halt_d;
  logic [APB_DATA_W-1:0] prdata_q, prdata_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      gpio_q   <= '0;
      hmask_q  <= '1;
      hstat_q  <= '0;
      hcnt_q   <= '0;
      halt_q   <= 1'b0;
      prdata_q <= '0;
    end else begin
      gpio_q   <= gpio_d;
      hmask_q  <= hmask_d;
      hstat_q  <= hstat_d;
      hcnt_q   <= hcnt_d;
      halt_q   <= halt_d;
      prdata_q <= prdata_d;
    end
  end

  always_comb begin
    logic [PINS-1:0]       wdat_pins;
    logic [CORES-1:0]      wdat_cores;
    logic [CORES-1:0]      w1c;
    logic [APB_DATA_W-1:0] rdata;

    wdat_pins  = S_PWDATA[PINS-1:0];
    wdat_cores = S_PWDATA[CORES-1:0];
    gpio_d     = gpio_q;
    hmask_d    = hmask_q;
    w1c        = '0;
    rdata      = '0;

    if (wr_en) begin
      case (int'(S_PADDR))
        APB_GPIOH_DATA:  gpio_d  = wdat_pins;
        APB_GPIOH_SET:   gpio_d  = gpio_q | wdat_pins;
        APB_GPIOH_CLR:   gpio_d  = gpio_q & ~wdat_pins;
        APB_GPIOH_TOG:   gpio_d  = gpio_q ^ wdat_pins;
        APB_GPIOH_HMASK: hmask_d = wdat_cores;
        APB_GPIOH_HSTAT: w1c     = wdat_cores;
        default: ;
      endcase
    end

    // Sticky status uses the pre-write mask; a live halt level beats w1c.
    hstat_d = (hstat_q & ~w1c) | (core_halt & hmask_q);

    // Evaluated on the next status so halt follows the last core by one clock.
    halt_d = (hmask_q != '0) && (&(hstat_d | ~hmask_q));

    // Counter stops while halted so the bench reads the run length afterwards.
    hcnt_d = (halt_q || (&hcnt_q)) ? hcnt_q : hcnt_q + 16'd1;

    case (int'(S_PADDR))
      APB_GPIOH_DATA:  rdata[PINS-1:0]  = gpio_q;
      APB_GPIOH_HMASK: rdata[CORES-1:0] = hmask_q;
      APB_GPIOH_HSTAT: rdata[CORES-1:0] = hstat_q;
      APB_GPIOH_HCNT:  rdata            = hcnt_q;
      default: ;
    endcase

    prdata_d = rd_en ? rdata : prdata_q;
  end

  assign gpio     = gpio_q;
  assign halt     = halt_q;
  assign S_PRDATA = prdata_q;

endmodule

// File: tb/tb_vmicro16_apb_gpio_halt.sv
// Directed + randomized bench for vmicro16_apb_gpio_halt with a transaction-level GPIO model.
module tb_vmicro16_apb_gpio_halt;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  paddr = '0;
  logic        psel = 1'b0, pen = 1'b0, pwrite = 1'b0;
  logic [15:0] pwdata = '0;
  logic [15:0] prdata;
  logic        pready;
  logic [3:0]  core_halt = '0;
  logic [15:0] gpio;
  logic        halt;

  always #5 clk = ~clk;

  vmicro16_apb_gpio_halt dut (
    .clk       (clk),
    .reset     (reset),
    .S_PADDR   (paddr),
    .S_PSELx   (psel),
    .S_PENABLE (pen),
    .S_PWRITE  (pwrite),
    .S_PWDATA  (pwdata),
    .S_PRDATA  (prdata),
    .S_PREADY  (pready),
    .core_halt (core_halt),
    .gpio      (gpio),
    .halt      (halt)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state (transaction level)
  logic [15:0] m_gpio;
  logic [3:0]  m_hmask, m_hstat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One APB transfer; returns read data and gpio sampled on the PREADY cycle.
  task automatic apb(input logic wr, input logic [2:0] a, input logic [15:0] d,
                     output logic [15:0] rd, output logic [15:0] g_at);
    bit seen;
    seen = 1'b0;
    g_at = 'x;
    @(posedge clk); #1;
    psel = 1'b1; pen = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge clk); #1;
    pen = 1'b1;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(posedge clk); #1;
      if (pready) begin
        seen = 1'b1;
        g_at = gpio;
      end
    end
    if (!seen) check("pready_timeout", 32'(pready), 32'd1);
    rd = prdata;
    @(posedge clk); #1;
    psel = 1'b0; pen = 1'b0; pwrite = 1'b0;
  endtask

  logic [15:0] rd, g, h1, h2, d;
  int          op;

  initial begin
    // Reset values
    repeat (4) @(posedge clk);
    #1;
    check("rst_gpio",   32'(gpio),   32'h0);
    check("rst_halt",   32'(halt),   32'h0);
    check("rst_pready", 32'(pready), 32'h0);
    check("rst_prdata", 32'(prdata), 32'h0);
    reset = 1'b0;

    // First read after reset sees two counted cycles (setup + wait state)
    apb(1'b0, 3'd6, 16'h0, rd, g);
    check("hcnt_first", 32'(rd), 32'h2);
    apb(1'b0, 3'd4, 16'h0, rd, g);
    check("rst_hmask", 32'(rd), 32'hF);
    m_hmask = 4'hF;
    m_hstat = 4'h0;
    apb(1'b0, 3'd5, 16'h0, rd, g);
    check("rst_hstat", 32'(rd), 32'(m_hstat));

    // Test 1: DATA write/read
    apb(1'b1, 3'd0, 16'h7008, rd, g);
    m_gpio = 16'h7008;
    check("t1_gpio_at_ready", 32'(g), 32'h7008);
    check("t1_pready_pulse", 32'(pready), 32'h0);
    apb(1'b0, 3'd0, 16'h0, rd, g);
    check("t1_read_data", 32'(rd), 32'h7008);

    // Test 2: SET/CLR/TOG
    apb(1'b1, 3'd0, 16'h00F0, rd, g); m_gpio = 16'h00F0;
    apb(1'b1, 3'd1, 16'h000F, rd, g); m_gpio = m_gpio | 16'h000F;
    apb(1'b1, 3'd2, 16'h0030, rd, g); m_gpio = m_gpio & ~16'h0030;
    apb(1'b1, 3'd3, 16'h8000, rd, g); m_gpio = m_gpio ^ 16'h8000;
    check("t2_gpio_const", 32'(gpio), 32'h80CF);
    check("t2_gpio_model", 32'(gpio), 32'(m_gpio));
    for (int a = 1; a <= 3; a++) begin
      apb(1'b0, 3'(a), 16'h0, rd, g);
      check($sformatf("t2_read_wo_%0d", a), 32'(rd), 32'h0);
    end
    apb(1'b0, 3'd7, 16'h0, rd, g);
    check("t2_read_off7", 32'(rd), 32'h0);
    apb(1'b1, 3'd7, 16'hFFFF, rd, g);
    check("t2_write_off7", 32'(gpio), 32'(m_gpio));

    // Randomized GPIO operations against the model
    for (int n = 0; n < 24; n++) begin
      op = int'($urandom_range(0, 3));
      d  = 16'($urandom);
      case (op)
        0: m_gpio = d;
        1: m_gpio = m_gpio | d;
        2: m_gpio = m_gpio & ~d;
        default: m_gpio = m_gpio ^ d;
      endcase
      apb(1'b1, 3'(op), d, rd, g);
      check($sformatf("rand_gpio_%0d_op%0d", n, op), 32'(g), 32'(m_gpio));
      if (n % 4 == 3) begin
        apb(1'b0, 3'd0, 16'h0, rd, g);
        check($sformatf("rand_read_%0d", n), 32'(rd), 32'(m_gpio));
      end
    end

    // Test 3: halt collection with mask 0101
    apb(1'b1, 3'd4, 16'h0005, rd, g);
    m_hmask = 4'b0101;
    core_halt = 4'b1011;
    repeat (5) @(posedge clk);
    #1;
    check("t3_halt_partial", 32'(halt), 32'h0);
    core_halt[2] = 1'b1;
    check("t3_halt_before_edge", 32'(halt), 32'h0);
    @(posedge clk); #1;
    check("t3_halt_rise", 32'(halt), 32'h1);
    m_hstat = m_hstat | (core_halt & m_hmask);
    apb(1'b0, 3'd5, 16'h0, rd, g);
    check("t3_hstat_masked", 32'(rd), 32'(m_hstat));
    apb(1'b0, 3'd6, 16'h0, rd, h1);
    h1 = rd;
    repeat (20) @(posedge clk);
    apb(1'b0, 3'd6, 16'h0, rd, g);
    h2 = rd;
    check("t3_hcnt_frozen", 32'(h2), 32'(h1));

    // Test 4: w1c clears halt, unless the core is still halted
    core_halt[2] = 1'b0;
    apb(1'b1, 3'd5, 16'h0004, rd, g);
    m_hstat = (m_hstat & ~4'b0100) | (core_halt & m_hmask);
    check("t4_halt_cleared", 32'(halt), 32'h0);
    apb(1'b0, 3'd5, 16'h0, rd, g);
    check("t4_hstat_after_w1c", 32'(rd), 32'(m_hstat));
    core_halt[2] = 1'b1;
    @(posedge clk); #1;
    check("t4_halt_reraise", 32'(halt), 32'h1);
    apb(1'b1, 3'd5, 16'h0004, rd, g);
    m_hstat = (m_hstat & ~4'b0100) | (core_halt & m_hmask);
    check("t4_halt_set_wins", 32'(halt), 32'h1);
    apb(1'b0, 3'd5, 16'h0, rd, g);
    check("t4_hstat_set_wins", 32'(rd), 32'(m_hstat));

    // Test 5: reset during a write access, before PREADY
    core_halt = 4'b0000;
    apb(1'b1, 3'd4, 16'h0003, rd, g);
    @(posedge clk); #1;
    psel = 1'b1; pen = 1'b0; pwrite = 1'b1; paddr = 3'd0; pwdata = 16'hBEEF;
    @(posedge clk); #1;
    pen = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("t5_pready_in_reset", 32'(pready), 32'h0);
    check("t5_gpio_in_reset", 32'(gpio), 32'h0);
    check("t5_halt_in_reset", 32'(halt), 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("t5_no_access_without_setup", 32'(pready), 32'h0);
    @(posedge clk); #1;
    check("t5_no_commit", 32'(gpio), 32'h0);
    psel = 1'b0; pen = 1'b0; pwrite = 1'b0;
    m_gpio = 16'h0; m_hmask = 4'hF; m_hstat = 4'h0;
    apb(1'b0, 3'd4, 16'h0, rd, g);
    check("t5_hmask_reset", 32'(rd), 32'(m_hmask));
    apb(1'b0, 3'd0, 16'h0, rd, g);
    check("t5_data_reset", 32'(rd), 32'(m_gpio));

    // Test 6: empty mask never halts; counter saturates
    apb(1'b1, 3'd4, 16'h0000, rd, g);
    core_halt = 4'hF;
    repeat (5) @(posedge clk);
    #1;
    check("t6_hmask0_halt", 32'(halt), 32'h0);
    repeat (70000) @(posedge clk);
    apb(1'b0, 3'd6, 16'h0, rd, g);
    check("t6_hcnt_sat", 32'(rd), 32'hFFFF);
    check("t6_halt_still0", 32'(halt), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
